// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle for seg_scan_ctrl: display data and update handshake in,
// scan select, anode/cathode drive and frame pulse out.
interface seg_scan_ctrl_if;
  logic [31:0] data;
  logic [7:0]  digit_en;
  logic        upd_req;
  logic        upd_ack;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        frame_tick;

  modport master (
    output data, digit_en, upd_req,
    input  upd_ack, sel, an, seg, frame_tick
  );

  modport slave (
    input  data, digit_en, upd_req,
    output upd_ack, sel, an, seg, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit seven-segment scan controller with frame-aligned data update.
// Define SCAN_DEADTIME_EN to blank the first DEAD_CYC cycles of every slot (anti-ghosting).
module seg_scan_ctrl #(
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned DEAD_CYC = 1000
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg_scan_ctrl: PRESCALE must be >= 2");
  end
  if (DEAD_CYC >= PRESCALE) begin : g_bad_dead
    $error("seg_scan_ctrl: DEAD_CYC must be < PRESCALE");
  end

  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    sel_q, sel_next;
  logic [31:0]   shadow, shadow_next;
  logic [7:0]    an_q, an_next;
  logic [6:0]    seg_q, seg_next;
  logic          ack_q, tick_q;
  logic          terminal, boundary, blank_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  always_comb begin
    terminal    = (cnt == CW'(PRESCALE - 1));
    boundary    = terminal && (sel_q == 3'd7);
    cnt_next    = terminal ? '0 : cnt + 1'b1;
    sel_next    = terminal ? sel_q + 3'd1 : sel_q;
    shadow_next = (boundary && bus.upd_req) ? bus.data : shadow;
  end

`ifdef SCAN_DEADTIME_EN
  typedef enum logic {SCAN, DEAD} state_t;
  state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= DEAD;
    else     state <= state_next;
  end

  // State tracks the upcoming cnt value so the blanking lines up with the registered an/seg.
  always_comb begin
    state_next = state;
    if (terminal)
      state_next = (DEAD_CYC == 0) ? SCAN : DEAD;
    else if (state == DEAD && cnt_next == CW'(DEAD_CYC))
      state_next = SCAN;
    blank_next = (state_next == DEAD);
  end
`else
  always_comb blank_next = 1'b0;
`endif

  // an/seg are computed from next-cycle sel/shadow so they switch on the same edge as sel.
  always_comb begin
    an_next  = '1;
    seg_next = '1;
    if (!blank_next && bus.digit_en[sel_next]) begin
      an_next  = ~(8'd1 << sel_next);
      seg_next = hex_to_seg(shadow_next[{sel_next, 2'b00} +: 4]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      sel_q  <= '0;
      shadow <= '0;
      an_q   <= '1;
      seg_q  <= '1;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      sel_q  <= sel_next;
      shadow <= shadow_next;
      an_q   <= an_next;
      seg_q  <= seg_next;
      ack_q  <= boundary && bus.upd_req;
      tick_q <= boundary;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.upd_ack    = ack_q;
  assign bus.frame_tick = tick_q;
endmodule
